// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-layer scheduler and its LIF datapath.
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    UPDATE,
    OUTPUT
  } state_t;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/snn_layer_scheduler_lif_update.sv
// Combinational leaky integrate-and-fire step: leak, add input, clamp, threshold and reset-by-subtraction.
module lif_update
  import snn_pkg::*;
#(
  parameter int POT_W      = 16,
  parameter int ACC_W      = 11,
  parameter int THRESHOLD  = 64,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [POT_W-1:0] pot,
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [POT_W-1:0] new_pot,
  output logic                    spike
);

  localparam int V_W = POT_W + 2;
  localparam logic signed [POT_W-1:0] THR = POT_W'(THRESHOLD);

  logic signed [V_W-1:0]   pot_x;
  logic signed [V_W-1:0]   acc_x;
  logic signed [V_W-1:0]   v;
  logic signed [POT_W-1:0] v_clamped;

  // Two guard bits keep the leak-plus-input sum exact before clamping.
  assign pot_x     = V_W'(pot);
  assign acc_x     = V_W'(acc);
  assign v         = pot_x - (pot_x >>> LEAK_SHIFT) + acc_x;
  assign v_clamped = POT_W'(saturate(64'(v), POT_W));
  assign spike     = (v_clamped >= THR);
  assign new_pot   = spike ? (v_clamped - THR) : v_clamped;

endmodule

// File: rtl/snn_layer_scheduler.sv
// One LIF layer time-multiplexed over a single datapath: per timestep, stream each neuron's
// weights from external memory, accumulate the active ones, then leak/clamp/fire.
module snn_layer_scheduler
  import snn_pkg::*;
#(
  parameter int INPUT_COUNT  = 4,
  parameter int NEURON_COUNT = 4,
  parameter int WEIGHT_W     = 8,
  parameter int POT_W        = 16,
  parameter int THRESHOLD    = 64,
  parameter int LEAK_SHIFT   = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [INPUT_COUNT-1:0]                        in_spikes,
  input  logic                                          clear_state,
  output logic                                          w_rd_en,
  output logic [$clog2(NEURON_COUNT*INPUT_COUNT)-1:0]   w_addr,
  input  logic signed [WEIGHT_W-1:0]                    w_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NEURON_COUNT-1:0]                       out_spikes,
  output logic                                          busy
);

  localparam int ADDR_W = $clog2(NEURON_COUNT * INPUT_COUNT);
  localparam int I_W    = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam int N_W    = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1;
  localparam int ACC_W  = WEIGHT_W + $clog2(INPUT_COUNT) + 1;
  localparam logic [I_W-1:0] I_LAST = I_W'(INPUT_COUNT - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NEURON_COUNT - 1);

  state_t                   state_reg;
  state_t                   state_next;
  logic [N_W-1:0]           n_reg;
  logic [I_W-1:0]           i_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [INPUT_COUNT-1:0]   spikes_reg;
  logic                     rd_d_reg;
  logic [I_W-1:0]           idx_d_reg;
  logic [NEURON_COUNT-1:0]  out_spikes_reg;
  logic signed [POT_W-1:0]  pot [NEURON_COUNT];
  logic signed [POT_W-1:0]  new_pot;
  logic                     spike_new;
  logic                     accept;

  assign accept     = in_valid && in_ready;
  assign out_spikes = out_spikes_reg;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // A clear request blocks acceptance for the same cycle.
        in_ready = !clear_state;
        if (in_valid && !clear_state) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        w_rd_en = 1'b1;
        w_addr  = ADDR_W'(int'(n_reg) * INPUT_COUNT + int'(i_reg));
        if (i_reg == I_LAST) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        state_next = UPDATE;
      end
      UPDATE: begin
        state_next = (n_reg == N_LAST) ? OUTPUT : ACCUM;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      i_reg          <= '0;
      acc_reg        <= '0;
      spikes_reg     <= '0;
      rd_d_reg       <= 1'b0;
      idx_d_reg      <= '0;
      out_spikes_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Weight returns one cycle after its read, so track which synapse it belongs to.
      rd_d_reg  <= (state_reg == ACCUM);
      idx_d_reg <= i_reg;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            spikes_reg <= in_spikes;
            n_reg      <= '0;
            i_reg      <= '0;
            acc_reg    <= '0;
          end
        end
        ACCUM, DRAIN: begin
          if (state_reg == ACCUM) begin
            i_reg <= (i_reg == I_LAST) ? '0 : i_reg + 1'b1;
          end
          if (rd_d_reg && spikes_reg[idx_d_reg]) begin
            acc_reg <= acc_reg + ACC_W'(w_data);
          end
        end
        UPDATE: begin
          out_spikes_reg[n_reg] <= spike_new;
          acc_reg               <= '0;
          i_reg                 <= '0;
          if (n_reg != N_LAST) begin
            n_reg <= n_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // One membrane register per neuron; only the neuron being updated loads.
  for (genvar gi = 0; gi < NEURON_COUNT; gi++) begin : g_neuron
    logic signed [POT_W-1:0] cell_pot_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cell_pot_reg <= '0;
      end else if (state_reg == IDLE && clear_state) begin
        cell_pot_reg <= '0;
      end else if (state_reg == UPDATE && n_reg == N_W'(gi)) begin
        cell_pot_reg <= new_pot;
      end
    end

    assign pot[gi] = cell_pot_reg;
  end

  lif_update #(
    .POT_W      (POT_W),
    .ACC_W      (ACC_W),
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_lif (
    .pot     (pot[n_reg]),
    .acc     (acc_reg),
    .new_pot (new_pot),
    .spike   (spike_new)
  );

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Directed bench: stimulus pushes expected spike vectors and latencies, a monitor pops on out_valid.
module tb_snn_layer_scheduler;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_spikes = 4'b0000;
  logic              clear_state = 1'b0;
  logic              w_rd_en;
  logic [3:0]        w_addr;
  logic signed [7:0] w_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [3:0]        out_spikes;
  logic              busy;

  logic              in_valid_s = 1'b0;
  logic              in_ready_s;
  logic              w_rd_en_s;
  logic [3:0]        w_addr_s;
  logic signed [7:0] w_data_s;
  logic              out_valid_s;
  logic [3:0]        out_spikes_s;
  logic              busy_s;

  logic signed [7:0] wmem [16];

  typedef struct {
    logic [3:0] sp;
    int         due;
  } exp_t;

  exp_t   q[$];
  exp_t   qs[$];
  exp_t   mon_e;
  exp_t   mon_es;
  logic [3:0] aq[$];
  int     cq[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  logic   ov_prev = 1'b0;
  logic   ovs_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snn_layer_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
    .clear_state(clear_state), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes), .busy(busy)
  );

  snn_layer_scheduler #(.POT_W(10), .THRESHOLD(511)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_spikes(4'b1111),
    .clear_state(1'b0), .w_rd_en(w_rd_en_s), .w_addr(w_addr_s), .w_data(w_data_s),
    .out_valid(out_valid_s), .out_ready(1'b1), .out_spikes(out_spikes_s), .busy(busy_s)
  );

  // External weight memories with one-cycle read latency.
  always @(posedge clk) if (w_rd_en) w_data <= wmem[w_addr];
  always @(posedge clk) if (w_rd_en_s) w_data_s <= 8'sd127;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask

  // Scoreboard monitor: compare on each rising out_valid.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && ov_prev !== 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got out_valid at cycle %0d expected none", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("out_spikes", out_spikes, mon_e.sp);
        chk("out_latency", cyc, mon_e.due);
        $display("out: cycle %0d spikes %b", cyc, out_spikes);
      end
    end
    ov_prev = out_valid;
    if (out_valid_s === 1'b1 && ovs_prev !== 1'b1) begin
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_out_unexpected: got out_valid at cycle %0d expected none", cyc);
      end else begin
        mon_es = qs.pop_front();
        chk("sat_out_spikes", out_spikes_s, mon_es.sp);
        chk("sat_out_latency", cyc, mon_es.due);
        $display("sat out: cycle %0d spikes %b", cyc, out_spikes_s);
      end
    end
    ovs_prev = out_valid_s;
  end

  always @(negedge clk) begin
    if (w_rd_en === 1'b1) begin
      aq.push_back(w_addr);
      cq.push_back(cyc);
    end
  end

  task automatic send(input logic [3:0] sp, input logic [3:0] ex, input bit expect_out);
    int k;
    exp_t e;
    @(negedge clk);
    in_spikes = sp;
    in_valid  = 1'b1;
    #1;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk("in_accept", in_ready, 1);
    if (in_ready === 1'b1 && expect_out) begin
      e.sp  = ex;
      e.due = cyc + 25;
      q.push_back(e);
    end
    $display("in: cycle %0d spikes %b", cyc, sp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 200) begin
      @(negedge clk); k++;
    end
    chk("out_timeout", out_valid, 1);
    @(negedge clk);
  endtask

  task automatic chk_pots(input int ex [4]);
    for (int k = 0; k < 4; k++) chk($sformatf("pot%0d", k), dut.pot[k], ex[k]);
  endtask

  task automatic check_addrs();
    logic bad;
    bad = 1'b0;
    chk("addr_count", aq.size(), 16);
    if (aq.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        if (aq[k] !== 4'(k)) bad = 1'b1;
        if (k > 0 && (cq[k] - cq[k-1]) != (((k % 4) == 0) ? 3 : 1)) bad = 1'b1;
      end
    end
    chk("addr_seq", bad, 0);
    aq.delete();
    cq.delete();
  endtask

  initial begin
    int seen;
    for (int a = 0; a < 16; a++) wmem[a] = 8'sd20;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_spikes", out_spikes, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_rd_en", w_rd_en, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_in_ready", in_ready, 1);
    aq.delete(); cq.delete();

    // Single timestep: 4*20=80 >= 64 -> fire, pot 16.
    send(4'b1111, 4'b1111, 1);
    wait_out();
    check_addrs();
    chk_pots('{16, 16, 16, 16});

    // Leak only: 16 - 2 = 14.
    send(4'b0000, 4'b0000, 1);
    wait_out();
    check_addrs();
    chk_pots('{14, 14, 14, 14});

    // Mixed signed weights, inputs 0 and 2 active.
    for (int a = 0; a < 16; a++) wmem[a] = 8'(a * 4 - 20);
    send(4'b0101, 4'b1000, 1);
    wait_out();
    check_addrs();
    chk_pots('{-19, 13, 45, 13});

    // Backpressure: hold outputs for 10 cycles.
    out_ready = 1'b0;
    send(4'b1111, 4'b1100, 1);
    seen = 0;
    while (out_valid !== 1'b1 && seen < 200) begin
      @(negedge clk); seen++;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, in_ready, w_rd_en, out_spikes}, {1'b1, 1'b0, 1'b0, 4'b1100});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {busy, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
    check_addrs();
    chk_pots('{-72, 20, 48, 84});

    // Reset in the middle of ACCUM: abort, clear potentials, no output.
    for (int a = 0; a < 16; a++) wmem[a] = 8'sd20;
    send(4'b1111, 4'b0000, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort", {busy, w_rd_en}, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("rst_no_out", seen, 0);
    chk_pots('{0, 0, 0, 0});
    aq.delete(); cq.delete();

    // Recovery timestep, then clear with simultaneous in_valid.
    send(4'b1111, 4'b1111, 1);
    wait_out();
    check_addrs();
    chk_pots('{16, 16, 16, 16});
    @(negedge clk);
    clear_state = 1'b1;
    in_valid    = 1'b1;
    in_spikes   = 4'b1111;
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(negedge clk);
    chk("clear_busy", busy, 0);
    clear_state = 1'b0;
    in_valid    = 1'b0;
    chk_pots('{0, 0, 0, 0});

    // Saturation instance: 508 without spike, then 953 clamps to 511 and fires.
    for (int st = 0; st < 2; st++) begin
      exp_t e;
      @(negedge clk);
      in_valid_s = 1'b1;
      #1;
      chk("sat_in_ready", in_ready_s, 1);
      e.sp  = (st == 0) ? 4'b0000 : 4'b1111;
      e.due = cyc + 25;
      qs.push_back(e);
      $display("sat in: cycle %0d step %0d", cyc, st);
      @(posedge clk); #1;
      in_valid_s = 1'b0;
      seen = 0;
      while (out_valid_s !== 1'b1 && seen < 200) begin
        @(negedge clk); seen++;
      end
      chk("sat_out_timeout", out_valid_s, 1);
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        chk($sformatf("sat_pot%0d", k), dut_s.pot[k], (st == 0) ? 508 : 0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size() + qs.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/snn_layer_scheduler.md
# snn_layer_scheduler

Time-multiplexed controller for one layer of spiking (leaky integrate-and-fire) neurons. Each accepted input spike vector is one timestep. For that timestep the block walks all NEURON_COUNT neurons in turn, streams each neuron's weights from an external weight memory, accumulates the weights of active inputs, then applies leak, saturation, threshold and reset. It sits between the input spike-encoder stream and the next layer or output counter, and replaces per-neuron combinational summing with one shared sequenced datapath.

## Interface
Parameters:
- INPUT_COUNT, 4: inputs (synapses) per neuron
- NEURON_COUNT, 4: neurons in the layer
- WEIGHT_W, 8: signed weight width
- POT_W, 16: signed membrane potential width
- THRESHOLD, 64: firing threshold (signed, POT_W)
- LEAK_SHIFT, 3: leak is pot >>> LEAK_SHIFT per timestep

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  spike vector valid
- in_ready  out  1  block accepts a spike vector
- in_spikes  in  INPUT_COUNT  input spikes for this timestep
- clear_state  in  1  zero all membrane potentials (sampled in IDLE only)
- w_rd_en  out  1  weight read strobe
- w_addr  out  $clog2(NEURON_COUNT*INPUT_COUNT)  weight address = n*INPUT_COUNT + i
- w_data  in  WEIGHT_W  signed weight, valid exactly 1 cycle after w_rd_en
- out_valid  out  1  output spike vector valid
- out_ready  in  1  downstream accepts
- out_spikes  out  NEURON_COUNT  layer spikes for the timestep
- busy  out  1  high in every state except IDLE

## Operation
- Potentials are held internally in NEURON_COUNT × POT_W signed registers.
- IDLE:
  - in_ready = !clear_state.
  - clear_state=1: all potentials become 0 and no vector is accepted. clear_state wins over a simultaneous in_valid.
  - in_valid && in_ready: capture in_spikes, set n=0, i=0, acc=0, go to ACCUM.
- ACCUM: each cycle, w_rd_en=1 and w_addr=n*INPUT_COUNT+i, then i++. The read is issued even when the spike bit is 0. After issuing i=INPUT_COUNT-1, go to DRAIN.
- Accumulate pipeline: a 1-cycle delayed copy of (read issued, i) adds sign-extended w_data to acc when captured spike bit i is set. This runs in ACCUM and DRAIN.
- DRAIN: one cycle that absorbs the last weight. Then go to UPDATE.
- UPDATE:
  - v = pot[n] - (pot[n] >>> LEAK_SHIFT) + acc, computed in POT_W+2 bits.
  - Clamp v to [-2^(POT_W-1), 2^(POT_W-1)-1].
  - If v ≥ THRESHOLD: out_spikes[n]=1 and pot[n]=v-THRESHOLD. Otherwise out_spikes[n]=0 and pot[n]=v.
  - If n==NEURON_COUNT-1, go to OUTPUT. Otherwise n++, i=0, acc=0, go to ACCUM.
- OUTPUT: out_valid=1 and out_spikes are held stable. On out_ready, go to IDLE.
- acc width is WEIGHT_W+$clog2(INPUT_COUNT)+1, signed, so it never overflows.
- Reset values: state=IDLE, all potentials 0, out_spikes=0, out_valid=0, w_rd_en=0, w_addr=0, busy=0, n=i=acc=0.
- rst in any state aborts the timestep immediately. No out_valid is produced and potentials clear.
- in_ready=0 and clear_state is ignored in every state other than IDLE.

## Timing
- Per neuron: INPUT_COUNT+2 cycles (ACCUM ×INPUT_COUNT, DRAIN, UPDATE).
- With the in handshake at cycle t, out_valid first rises at t+1+NEURON_COUNT*(INPUT_COUNT+2). For the defaults this is t+25.
- With out_ready held high, the handshake completes in the first OUTPUT cycle. in_ready rises the next cycle, so the minimum spacing between accepted vectors is NEURON_COUNT*(INPUT_COUNT+2)+2 cycles.
- w_addr sequence for one timestep is 0,1,…,NEURON_COUNT*INPUT_COUNT-1, with a gap of 2 idle cycles (w_rd_en=0) between neurons.
- out_spikes bits update in UPDATE cycles and are stable throughout OUTPUT.

## Structure
- Package snn_pkg holds:
  - the state enum (IDLE, ACCUM, DRAIN, UPDATE, OUTPUT);
  - a saturate function parameterised by width.
- The natural sub-module is lif_update: purely combinational leak, add, clamp and threshold.
  - Inputs: pot, acc.
  - Outputs: new_pot, spike.
  - It is reused by future multi-layer schedulers.
- The weight memory is external (ROM/BRAM with 1-cycle read latency) and is not part of this block.

## Test plan
Defaults apply unless stated.
- **Reset:** hold rst 3 cycles. Then out_valid=0, out_spikes=0, busy=0, w_rd_en=0, and in_ready=1 on the first cycle after deassertion.
- **Single timestep:**
  - Setup: all 16 weights = 20, in_spikes=4'b1111 at t.
  - Required: w_addr runs 0..15, out_valid at t+25, out_spikes=4'b1111, all potentials 16.
- **Leak, no input:** follow the single-timestep case with in_spikes=4'b0000. Required: v=16-2=14 for every neuron, out_spikes=4'b0000, potentials 14.
- **Saturation:**
  - Setup: POT_W=10, THRESHOLD=511, all weights 127, all spikes on.
  - Step 1 → pot 508, no spike.
  - Step 2 → v=953 clamps to 511, spike=1, pot=0.
- **Backpressure:** out_ready low for 10 cycles. Required: out_valid and out_spikes stable, in_ready=0, w_rd_en=0 throughout; IDLE is entered the cycle after out_ready rises.
- **Clear and reset mid-operation:**
  - clear_state and in_valid high together in IDLE → in_ready=0, nothing accepted, potentials 0.
  - rst asserted mid-ACCUM → IDLE next cycle, out_valid never asserted.
